// File: rtl/char_anim_pkg.sv
// Shared definitions for the character animation sequencer.
// Holds the frame-rate tuning constants, Mario pose encodings, the Kong
// animation state encoding and the Mario jump FSM states.
// No ports (package).
package char_anim_pkg;

  localparam int SPRITE_W = 16;

  localparam logic [8:0] FLOOR_Y = 9'd400;
  localparam logic [9:0] X_MAX   = 10'(640 - SPRITE_W);

  localparam int MARIO_STEP  = 2;
  localparam int JUMP_STEP   = 3;
  localparam int JUMP_FRAMES = 8;
  localparam int WALK_DIV    = 4;
  localparam int KONG_IDLE   = 60;
  localparam int KONG_HOLD   = 10;
  localparam int QUEUE_DIV   = 30;

  localparam logic [2:0] POSE_STAND  = 3'd0;
  localparam logic [2:0] POSE_WALK_A = 3'd1;
  localparam logic [2:0] POSE_WALK_B = 3'd2;
  localparam logic [2:0] POSE_JUMP   = 3'd3;

  typedef enum logic [1:0] {
    KONG_ST_IDLE      = 2'd0,
    KONG_ST_ARMS_UP   = 2'd1,
    KONG_ST_THROW     = 2'd2,
    KONG_ST_ARMS_DOWN = 2'd3
  } kong_state_t;

  typedef enum logic [1:0] {
    JUMP_GROUND = 2'd0,
    JUMP_RISE   = 2'd1,
    JUMP_FALL   = 2'd2
  } jump_state_t;

endpackage

// File: rtl/kong_anim_seq.sv
// Kong animation sequencer: idle for KONG_IDLE frames, then arms-up,
// throw and arms-down for KONG_HOLD frames each, back to idle.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   tick         frame advance strobe (already gated by any pause)
//   kong_state   current pose (0 idle, 1 arms-up, 2 throw, 3 arms-down)
//   kong_throw   one-cycle pulse on the edge that enters THROW
module kong_anim_seq
  import char_anim_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  output logic [1:0] kong_state,
  output logic       kong_throw
);

  kong_state_t state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        throw_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= KONG_ST_IDLE;
      cnt_q      <= 6'd0;
      kong_throw <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kong_throw <= throw_d;
    end
  end

  // cnt_q is the number of frames already shown in the current state, so a
  // state is left on the tick after it has been displayed for its full hold.
  // Out of reset the idle count starts at 0 and re-entry starts at 1, which
  // gives every state exactly its nominal number of displayed frames.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    throw_d = 1'b0;
    if (tick) begin
      cnt_d = cnt_q + 6'd1;
      case (state_q)
        KONG_ST_IDLE: begin
          if (cnt_q == 6'(KONG_IDLE)) begin
            state_d = KONG_ST_ARMS_UP;
            cnt_d   = 6'd1;
          end
        end
        KONG_ST_ARMS_UP: begin
          if (cnt_q == 6'(KONG_HOLD)) begin
            state_d = KONG_ST_THROW;
            cnt_d   = 6'd1;
            throw_d = 1'b1;
          end
        end
        KONG_ST_THROW: begin
          if (cnt_q == 6'(KONG_HOLD)) begin
            state_d = KONG_ST_ARMS_DOWN;
            cnt_d   = 6'd1;
          end
        end
        default: begin
          if (cnt_q == 6'(KONG_HOLD)) begin
            state_d = KONG_ST_IDLE;
            cnt_d   = 6'd1;
          end
        end
      endcase
    end
  end

  assign kong_state = state_q;

endmodule

// File: rtl/character_anim_ctrl.sv
// Per-frame sequencer for the character sprite colour mux. Owns Mario
// position, facing and pose (including the jump arc), the Kong animation
// cycle and the "help" queue toggle. State only advances on frame_tick so
// sprite inputs are stable across each visible frame; all outputs registered.
// Optional build macro: CHAR_PAUSE_EN adds a pause input that freezes all
// state (and suppresses kong_throw) while high.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   frame_tick        one-cycle pulse at start of vblank
//   btn_left/right    level, horizontal move request
//   btn_jump          level, jump request (honoured only on the ground)
//   pause             (CHAR_PAUSE_EN only) freeze frame advance
//   mario_state       [3] facing (1=left), [2:0] pose
//   mario_posx/posy   sprite left column / top row
//   kong_state        Kong pose, kong_throw one-cycle barrel spawn pulse
//   queue_state       help-frame toggle
module character_anim_ctrl
  import char_anim_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
`ifdef CHAR_PAUSE_EN
  input  logic       pause,
`endif
  output logic [3:0] mario_state,
  output logic [9:0] mario_posx,
  output logic [8:0] mario_posy,
  output logic [1:0] kong_state,
  output logic       kong_throw,
  output logic       queue_state
);

  logic adv;
`ifdef CHAR_PAUSE_EN
  assign adv = frame_tick & ~pause;
`else
  assign adv = frame_tick;
`endif

  jump_state_t jump_q, jump_d;
  logic [9:0]  posx_q, posx_d;
  logic [8:0]  posy_q, posy_d;
  logic        facing_q, facing_d;
  logic [2:0]  pose_q, pose_d;
  logic [2:0]  rise_cnt_q, rise_cnt_d;
  logic [2:0]  walk_cnt_q, walk_cnt_d;
  logic        walk_phase_q, walk_phase_d;
  logic [4:0]  queue_cnt_q, queue_cnt_d;
  logic        queue_q, queue_d;

  logic        move_l, move_r;
  logic [10:0] posx_ext, posy_ext;

  assign move_l   = btn_left & ~btn_right;
  assign move_r   = btn_right & ~btn_left;
  assign posx_ext = {1'b0, posx_q};
  assign posy_ext = {2'b00, posy_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_q       <= JUMP_GROUND;
      posx_q       <= 10'd0;
      posy_q       <= FLOOR_Y;
      facing_q     <= 1'b0;
      pose_q       <= POSE_STAND;
      rise_cnt_q   <= 3'd0;
      walk_cnt_q   <= 3'd0;
      walk_phase_q <= 1'b0;
      queue_cnt_q  <= 5'd0;
      queue_q      <= 1'b0;
    end else begin
      jump_q       <= jump_d;
      posx_q       <= posx_d;
      posy_q       <= posy_d;
      facing_q     <= facing_d;
      pose_q       <= pose_d;
      rise_cnt_q   <= rise_cnt_d;
      walk_cnt_q   <= walk_cnt_d;
      walk_phase_q <= walk_phase_d;
      queue_cnt_q  <= queue_cnt_d;
      queue_q      <= queue_d;
    end
  end

  always_comb begin
    jump_d       = jump_q;
    posx_d       = posx_q;
    posy_d       = posy_q;
    facing_d     = facing_q;
    pose_d       = pose_q;
    rise_cnt_d   = rise_cnt_q;
    walk_cnt_d   = walk_cnt_q;
    walk_phase_d = walk_phase_q;
    queue_cnt_d  = queue_cnt_q;
    queue_d      = queue_q;

    if (adv) begin
      // Horizontal: 11-bit arithmetic so neither edge can wrap.
      if (move_l) begin
        facing_d = 1'b1;
        if (posx_ext < 11'(MARIO_STEP)) posx_d = 10'd0;
        else                            posx_d = 10'(posx_ext - 11'(MARIO_STEP));
      end else if (move_r) begin
        facing_d = 1'b0;
        if (posx_ext + 11'(MARIO_STEP) > {1'b0, X_MAX}) posx_d = X_MAX;
        else                                           posx_d = 10'(posx_ext + 11'(MARIO_STEP));
      end

      // Jump arc. The tick that starts a jump only changes state; the
      // vertical motion begins on the following tick.
      case (jump_q)
        JUMP_GROUND: begin
          if (btn_jump) begin
            jump_d     = JUMP_RISE;
            rise_cnt_d = 3'd0;
          end
        end
        JUMP_RISE: begin
          posy_d     = posy_q - 9'(JUMP_STEP);
          rise_cnt_d = rise_cnt_q + 3'd1;
          if (rise_cnt_q == 3'(JUMP_FRAMES - 1)) jump_d = JUMP_FALL;
        end
        default: begin
          if (posy_ext + 11'(JUMP_STEP) >= {2'b00, FLOOR_Y}) begin
            posy_d = FLOOR_Y;
            jump_d = JUMP_GROUND;
          end else begin
            posy_d = 9'(posy_ext + 11'(JUMP_STEP));
          end
        end
      endcase

      // Pose follows the post-tick jump state, so the launch tick already
      // shows the jump pose and the landing tick shows a ground pose.
      if (jump_d != JUMP_GROUND) begin
        pose_d       = POSE_JUMP;
        walk_cnt_d   = 3'd0;
        walk_phase_d = 1'b0;
      end else if (move_l || move_r) begin
        // walk_cnt_q counts frames already shown in the current walk phase.
        if (walk_cnt_q == 3'(WALK_DIV)) begin
          walk_phase_d = ~walk_phase_q;
          walk_cnt_d   = 3'd1;
        end else begin
          walk_cnt_d   = walk_cnt_q + 3'd1;
        end
        pose_d = walk_phase_d ? POSE_WALK_B : POSE_WALK_A;
      end else begin
        pose_d       = POSE_STAND;
        walk_cnt_d   = 3'd0;
        walk_phase_d = 1'b0;
      end

      if (queue_cnt_q == 5'(QUEUE_DIV - 1)) begin
        queue_cnt_d = 5'd0;
        queue_d     = ~queue_q;
      end else begin
        queue_cnt_d = queue_cnt_q + 5'd1;
      end
    end
  end

  kong_anim_seq u_kong (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (adv),
    .kong_state (kong_state),
    .kong_throw (kong_throw)
  );

  assign mario_state = {facing_q, pose_q};
  assign mario_posx  = posx_q;
  assign mario_posy  = posy_q;
  assign queue_state = queue_q;

endmodule

// File: tb/tb_character_anim_ctrl.sv
// Directed bench for character_anim_ctrl: reset values, Kong/queue cycle,
// walking and edge saturation, jump arc, back-to-back ticks, async reset
// mid-jump and (CHAR_PAUSE_EN builds) pause freezing.
module tb_character_anim_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
`ifdef CHAR_PAUSE_EN
  logic       pause;
`endif
  logic [3:0] mario_state;
  logic [9:0] mario_posx;
  logic [8:0] mario_posy;
  logic [1:0] kong_state;
  logic       kong_throw;
  logic       queue_state;

  int checks;
  int errors;
  logic [1:0] exp_q[$];

  character_anim_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_jump    (btn_jump),
`ifdef CHAR_PAUSE_EN
    .pause       (pause),
`endif
    .mario_state (mario_state),
    .mario_posx  (mario_posx),
    .mario_posy  (mario_posy),
    .kong_state  (kong_state),
    .kong_throw  (kong_throw),
    .queue_state (queue_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0; frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // driver: one frame tick with the given buttons; returns at the negedge
  // after the update edge so outputs can be sampled directly.
  task automatic frame(input logic l, input logic r, input logic j);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  initial begin
    logic [9:0] hold_x;
    logic [1:0] exp_k;
    logic [1:0] hold_k;
    logic       hold_q;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
`ifdef CHAR_PAUSE_EN
    pause = 1'b0;
`endif

    // reset values
    apply_reset();
    check("rst_posx", mario_posx, 0);
    check("rst_posy", mario_posy, 400);
    check("rst_mstate", mario_state, 0);
    check("rst_kong", kong_state, 0);
    check("rst_throw", kong_throw, 0);
    check("rst_queue", queue_state, 0);

    // Kong and queue cycle over 96 idle frames
    for (int n = 1; n <= 96; n++) begin
      if (n <= 60)      exp_q.push_back(2'd0);
      else if (n <= 70) exp_q.push_back(2'd1);
      else if (n <= 80) exp_q.push_back(2'd2);
      else if (n <= 90) exp_q.push_back(2'd3);
      else              exp_q.push_back(2'd0);
    end
    for (int n = 1; n <= 96; n++) begin
      frame(1'b0, 1'b0, 1'b0);
      exp_k = exp_q.pop_front();
      check("kong_state", kong_state, exp_k);
      check("kong_throw", kong_throw, (n == 71) ? 1 : 0);
      check("queue_state", queue_state, (n / 30) % 2);
      if (n == 5) begin
        check("idle_posx", mario_posx, 0);
        check("idle_posy", mario_posy, 400);
        check("idle_mstate", mario_state, 0);
      end
      if (n == 71) begin
        @(negedge clk);
        check("kong_throw_width", kong_throw, 0);
      end
    end

    // walking right 10 frames, pose 1,1,1,1,2,2,2,2,1,1
    apply_reset();
    for (int n = 1; n <= 10; n++) begin
      frame(1'b0, 1'b1, 1'b0);
      check("walk_posx", mario_posx, 2 * n);
      check("walk_mstate", mario_state, (((n - 1) / 4) % 2 == 1) ? 2 : 1);
    end
    // no change between ticks
    repeat (3) @(negedge clk);
    check("hold_posx", mario_posx, 20);
    frame(1'b1, 1'b0, 1'b0);
    check("left_posx", mario_posx, 18);
    check("left_mstate", mario_state, 4'h9);
    // both buttons: no move, facing held, pose stand
    frame(1'b1, 1'b1, 1'b0);
    check("both_posx", mario_posx, 18);
    check("both_mstate", mario_state, 4'h8);
    // saturate at left edge
    repeat (9) frame(1'b1, 1'b0, 1'b0);
    check("sat0_posx", mario_posx, 0);
    frame(1'b1, 1'b0, 1'b0);
    check("sat0_posx_hold", mario_posx, 0);
    check("sat0_facing", mario_state[3], 1);
    // saturate at right edge
    repeat (311) frame(1'b0, 1'b1, 1'b0);
    check("satmax_622", mario_posx, 622);
    check("satmax_facing", mario_state[3], 0);
    frame(1'b0, 1'b1, 1'b0);
    check("satmax_624", mario_posx, 624);
    frame(1'b0, 1'b1, 1'b0);
    check("satmax_hold", mario_posx, 624);

    // single jump: launch frame, 8 rising, 8 falling
    apply_reset();
    frame(1'b0, 1'b0, 1'b1);
    check("jump_launch_posy", mario_posy, 400);
    check("jump_launch_pose", mario_state, 3);
    for (int k = 1; k <= 8; k++) begin
      frame(1'b0, 1'b0, 1'b0);
      check("rise_posy", mario_posy, 400 - 3 * k);
      check("rise_pose", mario_state, 3);
    end
    for (int k = 1; k <= 8; k++) begin
      frame(1'b0, 1'b0, 1'b0);
      check("fall_posy", mario_posy, 376 + 3 * k);
      check("fall_pose", mario_state, (k == 8) ? 0 : 3);
    end

    // jump held throughout: lands on frame 17, relaunches on frame 18
    apply_reset();
    for (int n = 1; n <= 19; n++) begin
      frame(1'b0, 1'b0, 1'b1);
      if (n == 1 || n == 17 || n == 18) check("held_posy", mario_posy, 400);
      else if (n <= 9)  check("held_posy", mario_posy, 400 - 3 * (n - 1));
      else if (n <= 16) check("held_posy", mario_posy, 376 + 3 * (n - 9));
      else              check("held_posy", mario_posy, 397);
      check("held_pose", mario_state, (n == 17) ? 0 : 3);
    end

    // airborne horizontal movement
    apply_reset();
    frame(1'b0, 1'b1, 1'b1);
    frame(1'b0, 1'b1, 1'b0);
    check("air_posx", mario_posx, 4);
    check("air_posy", mario_posy, 397);
    check("air_pose", mario_state, 3);

    // back-to-back ticks: two consecutive cycles = two updates
    apply_reset();
    @(negedge clk);
    btn_right = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    btn_right = 1'b0;
    check("b2b_posx", mario_posx, 4);

    // async reset mid-jump
    apply_reset();
    frame(1'b0, 1'b0, 1'b1);
    repeat (3) frame(1'b0, 1'b0, 1'b0);
    check("midjump_posy", mario_posy, 391);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midjump_rst_posy", mario_posy, 400);
    check("midjump_rst_pose", mario_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    frame(1'b0, 1'b0, 1'b0);
    check("after_rst_posy", mario_posy, 400);

`ifdef CHAR_PAUSE_EN
    // pause freezes everything
    apply_reset();
    repeat (3) frame(1'b0, 1'b1, 1'b0);
    hold_x = mario_posx;
    hold_k = kong_state;
    hold_q = queue_state;
    pause = 1'b1;
    repeat (20) frame(1'b0, 1'b1, 1'b0);
    check("pause_posx", mario_posx, hold_x);
    check("pause_kong", kong_state, hold_k);
    check("pause_queue", queue_state, hold_q);
    pause = 1'b0;
    frame(1'b0, 1'b1, 1'b0);
    check("resume_posx", mario_posx, 8);
`else
    hold_x = 10'd0;
    hold_k = 2'd0;
    hold_q = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
